// File: rtl/sm_fxd_pkg.sv
// Sign-magnitude fixed-point helpers shared by the add/sub pipeline.
// Define SM_ADDSUB_SAT_EN to saturate on magnitude overflow; otherwise results wrap.
package sm_fxd_pkg;

`ifdef SM_ADDSUB_SAT_EN
  localparam bit SM_SAT = 1'b1;
`else
  localparam bit SM_SAT = 1'b0;
`endif

  // Functions work on a fixed maximum word; the caller passes the real width n.
  localparam int unsigned SM_MAX_N = 32;
  typedef logic [SM_MAX_N-1:0] sm_word_t;

  function automatic sm_word_t sm_mask(input int unsigned n);
    return sm_word_t'((64'd1 << (n - 1)) - 64'd1);
  endfunction

  function automatic logic sm_sign(input sm_word_t x, input int unsigned n);
    return 1'(x >> (n - 1));
  endfunction

  function automatic sm_word_t sm_mag(input sm_word_t x, input int unsigned n);
    return x & sm_mask(n);
  endfunction

  // Returns {ovf, data}; data occupies the low n bits.
  function automatic logic [SM_MAX_N:0] sm_addsub(input sm_word_t a, input sm_word_t b,
                                                  input logic sub, input int unsigned n);
    logic     s1, s2, s, carry;
    sm_word_t m1, m2, mag, sum, mask;
    mask  = sm_mask(n);
    s1    = sm_sign(a, n);
    s2    = sm_sign(b, n) ^ sub;
    m1    = sm_mag(a, n);
    m2    = sm_mag(b, n);
    carry = 1'b0;
    sum   = '0;
    if (s1 == s2) begin
      sum   = m1 + m2;
      s     = s1;
      carry = 1'(sum >> (n - 1));
      mag   = sum & mask;
    end else if (m1 >= m2) begin
      s   = s1;
      mag = m1 - m2;
    end else begin
      s   = s2;
      mag = m2 - m1;
    end
    if (carry && SM_SAT) mag = mask;
    // A genuine zero is always +0; a wrapped overflow keeps its sign.
    if (mag == '0 && !carry) s = 1'b0;
    return {carry, (sm_word_t'(s) << (n - 1)) | mag};
  endfunction

endpackage

// File: rtl/sm_pipe_stage.sv
// One valid/ready register slice: holds its word while downstream is not ready.
module sm_pipe_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  input  logic         out_rdy
);
  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;

  assign in_rdy   = !vld_q | out_rdy;
  assign out_vld  = vld_q;
  assign out_data = data_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (in_rdy) begin
      vld_d = in_vld;
      if (in_vld) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/sm_addsub_pipe.sv
// Pipelined sign-magnitude adder/subtractor joining two operand streams.
// Build option: SM_ADDSUB_SAT_EN selects saturation instead of wrap on overflow.
module sm_addsub_pipe
  import sm_fxd_pkg::*;
#(
  parameter int FXD_Q      = 4,
  parameter int FXD_N      = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pre_avail_1,
  output logic             pre_get_1,
  input  logic [FXD_N-1:0] pre_data_1,
  input  logic             pre_avail_2,
  output logic             pre_get_2,
  input  logic [FXD_N-1:0] pre_data_2,
  input  logic             pre_sub,
  output logic             post_avail,
  input  logic             post_get,
  output logic [FXD_N-1:0] post_data,
  output logic             post_ovf
);
  // FXD_Q only documents the binary point; it never changes the datapath.
  localparam int W = FXD_N + 1 + 0 * FXD_Q;

  logic         vld_w [NUM_STAGES+1];
  logic         rdy_w [NUM_STAGES+1];
  logic [W-1:0] dat_w [NUM_STAGES+1];
  logic         accept;

  // Reset gating keeps both gets low while rst_n is asserted.
  assign accept      = pre_avail_1 & pre_avail_2 & rdy_w[0] & rst_n;
  assign pre_get_1   = accept;
  assign pre_get_2   = accept;
  assign vld_w[0]    = accept;
  assign rdy_w[NUM_STAGES] = post_get;

  always_comb begin : arith
    logic [SM_MAX_N:0] res;
    res      = sm_addsub(sm_word_t'(pre_data_1), sm_word_t'(pre_data_2), pre_sub, FXD_N);
    dat_w[0] = {res[SM_MAX_N], res[FXD_N-1:0]};
  end

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    sm_pipe_stage #(.W(W)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (vld_w[gi]),
      .in_data  (dat_w[gi]),
      .in_rdy   (rdy_w[gi]),
      .out_vld  (vld_w[gi+1]),
      .out_data (dat_w[gi+1]),
      .out_rdy  (rdy_w[gi+1])
    );
  end

  assign post_avail = vld_w[NUM_STAGES];
  assign post_ovf   = dat_w[NUM_STAGES][W-1];
  assign post_data  = dat_w[NUM_STAGES][FXD_N-1:0];
endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Self-checking bench: a 2-stage instance for arithmetic/latency/reset, a 3-stage one for join and backpressure.
module tb_sm_addsub_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_av1, a_av2, a_sub, a_pget, a_g1, a_g2, a_pav, a_ovf;
  logic [7:0] a_d1, a_d2, a_pd;
  logic       b_av1, b_av2, b_sub, b_pget, b_g1, b_g2, b_pav, b_ovf;
  logic [7:0] b_d1, b_d2, b_pd;

  sm_addsub_pipe #(.FXD_Q(4), .FXD_N(8), .NUM_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .pre_avail_1(a_av1), .pre_get_1(a_g1), .pre_data_1(a_d1),
    .pre_avail_2(a_av2), .pre_get_2(a_g2), .pre_data_2(a_d2),
    .pre_sub(a_sub), .post_avail(a_pav), .post_get(a_pget),
    .post_data(a_pd), .post_ovf(a_ovf)
  );

  sm_addsub_pipe #(.FXD_Q(4), .FXD_N(8), .NUM_STAGES(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .pre_avail_1(b_av1), .pre_get_1(b_g1), .pre_data_1(b_d1),
    .pre_avail_2(b_av2), .pre_get_2(b_g2), .pre_data_2(b_d2),
    .pre_sub(b_sub), .post_avail(b_pav), .post_get(b_pget),
    .post_data(b_pd), .post_ovf(b_ovf)
  );

  // Reference: convert to signed integers, do plain arithmetic, convert back.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic sub);
    int v1, v2, r, m;
    logic ovf, s;
    logic [6:0] mag;
    v1  = x[7] ? -int'(x[6:0]) : int'(x[6:0]);
    v2  = y[7] ? -int'(y[6:0]) : int'(y[6:0]);
    r   = sub ? v1 - v2 : v1 + v2;
    m   = (r < 0) ? -r : r;
    ovf = (m > 127);
    s   = (r < 0);
    mag = 7'(m % 128);
`ifdef SM_ADDSUB_SAT_EN
    if (ovf) mag = 7'h7F;
`endif
    return {ovf, s, mag};
  endfunction

  logic [7:0] dir_a   [7] = '{8'h18, 8'h18, 8'h98, 8'h18, 8'h80, 8'h7F, 8'hFF};
  logic [7:0] dir_b   [7] = '{8'h24, 8'h24, 8'h98, 8'h98, 8'h05, 8'h01, 8'h81};
  logic       dir_sub [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef SM_ADDSUB_SAT_EN
  logic [7:0] dir_exp [7] = '{8'h3C, 8'h8C, 8'h00, 8'h00, 8'h05, 8'h7F, 8'hFF};
`else
  logic [7:0] dir_exp [7] = '{8'h3C, 8'h8C, 8'h00, 8'h00, 8'h05, 8'h00, 8'h80};
`endif
  logic       dir_ovf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic test_reset();
    a_av1 = 1; a_av2 = 1; b_av1 = 1; b_av2 = 1;
    #12;
    checks++;
    if (a_pav !== 1'b0 || a_pd !== 8'h00 || a_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got avail=%b data=%h ovf=%b expected 0 00 0", a_pav, a_pd, a_ovf);
    end
    checks++;
    if (a_g1 !== 1'b0 || a_g2 !== 1'b0 || b_g1 !== 1'b0 || b_pav !== 1'b0) begin
      errors++;
      $display("FAIL reset_gets got a_get=%b%b b_get=%b b_avail=%b expected 0", a_g1, a_g2, b_g1, b_pav);
    end
    a_av1 = 0; a_av2 = 0; b_av1 = 0; b_av2 = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    for (int i = 0; i < 7; i++) begin
      int cyc;
      a_av1 = 1; a_av2 = 1; a_d1 = dir_a[i]; a_d2 = dir_b[i]; a_sub = dir_sub[i]; a_pget = 1;
      #1;
      checks++;
      if (a_g1 !== 1'b1 || a_g2 !== 1'b1) begin
        errors++;
        $display("FAIL directed%0d_accept got %b%b expected 11", i, a_g1, a_g2);
      end
      @(posedge clk); #1;
      a_av1 = 0; a_av2 = 0;
      cyc = 1;
      while (a_pav !== 1'b1 && cyc < 10) begin
        @(posedge clk); #1;
        cyc++;
      end
      checks++;
      if (cyc != 2) begin
        errors++;
        $display("FAIL directed%0d_latency got %0d expected 2", i, cyc);
      end
      checks++;
      if (a_pd !== dir_exp[i] || a_ovf !== dir_ovf[i]) begin
        errors++;
        $display("FAIL directed%0d_result got %h ovf=%b expected %h ovf=%b", i, a_pd, a_ovf, dir_exp[i], dir_ovf[i]);
      end
      $display("directed %0d: %h %s %h -> %h ovf=%b", i, dir_a[i], dir_sub[i] ? "-" : "+", dir_b[i], a_pd, a_ovf);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q [$];
    logic [8:0] e;
    a_pget = 1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        a_av1 = 1; a_av2 = 1;
        a_d1 = 8'($urandom); a_d2 = 8'($urandom); a_sub = 1'($urandom);
        exp_q.push_back(model(a_d1, a_d2, a_sub));
      end else begin
        a_av1 = 0; a_av2 = 0;
      end
      #1;
      if (c < 8) begin
        checks++;
        if (a_g1 !== 1'b1) begin
          errors++;
          $display("FAIL b2b_accept cycle %0d got %b expected 1", c, a_g1);
        end
      end
      if (c >= 2 && c < 10) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        checks++;
        if (a_pav !== 1'b1 || {a_ovf, a_pd} !== e) begin
          errors++;
          $display("FAIL b2b_result cycle %0d got avail=%b %h expected avail=1 %h", c, a_pav, {a_ovf, a_pd}, e);
        end
        $display("b2b cycle %0d: result %h", c, {a_ovf, a_pd});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [8:0] exp_q [$];
    logic [8:0] e;
    int sent = 0;
    int recv = 0;
    for (int c = 0; c < 2000 && recv < 40; c++) begin
      a_av1 = ($urandom_range(0, 3) != 0) && (sent < 40);
      a_av2 = ($urandom_range(0, 3) != 0) && (sent < 40);
      a_d1 = 8'($urandom); a_d2 = 8'($urandom); a_sub = 1'($urandom);
      a_pget = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (a_g1 !== a_g2 || (a_g1 && !(a_av1 && a_av2))) begin
        errors++;
        $display("FAIL rand_join got get=%b%b expected equal gets only with both avail=%b%b", a_g1, a_g2, a_av1, a_av2);
      end
      if (a_g1 === 1'b1) begin
        exp_q.push_back(model(a_d1, a_d2, a_sub));
        sent++;
      end
      if (a_pav === 1'b1 && a_pget) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        checks++;
        if ({a_ovf, a_pd} !== e) begin
          errors++;
          $display("FAIL rand_result %0d got %h expected %h", recv, {a_ovf, a_pd}, e);
        end
        $display("random %0d: result %h", recv, {a_ovf, a_pd});
        recv++;
      end
      @(posedge clk); #1;
    end
    a_av1 = 0; a_av2 = 0; a_pget = 1;
    checks++;
    if (recv != 40) begin
      errors++;
      $display("FAIL rand_count got %0d expected 40", recv);
    end
  endtask

  task automatic test_join_backpressure();
    logic [7:0] op1 [5];
    logic [7:0] op2 [5];
    logic       ops [5];
    logic [8:0] exp_q [$];
    logic [8:0] e;
    int idx = 0;
    int recv = 0;
    int dup = 0;
    for (int i = 0; i < 5; i++) begin
      op1[i] = 8'($urandom); op2[i] = 8'($urandom); ops[i] = 1'($urandom);
    end
    b_av1 = 1; b_av2 = 0; b_pget = 0; b_sub = 0; b_d1 = 8'h11; b_d2 = 8'h22;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (b_g1 !== 1'b0 || b_g2 !== 1'b0) begin
        errors++;
        $display("FAIL join_single got get=%b%b expected 00", b_g1, b_g2);
      end
      @(posedge clk); #1;
    end
    for (int c = 0; c < 8; c++) begin
      b_av1 = 1; b_av2 = 1;
      b_d1 = op1[idx]; b_d2 = op2[idx]; b_sub = ops[idx];
      #1;
      if (b_g1 === 1'b1) begin
        exp_q.push_back(model(op1[idx], op2[idx], ops[idx]));
        idx++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL bp_accepted got %0d expected 3", idx);
    end
    #1;
    checks++;
    if (b_g1 !== 1'b0 || b_g2 !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_get got %b%b expected 00", b_g1, b_g2);
    end
    b_pget = 1;
    for (int c = 0; c < 40 && recv < 5; c++) begin
      b_av1 = (idx < 5); b_av2 = (idx < 5);
      if (idx < 5) begin b_d1 = op1[idx]; b_d2 = op2[idx]; b_sub = ops[idx]; end
      #1;
      if (b_g1 === 1'b1) begin
        exp_q.push_back(model(op1[idx], op2[idx], ops[idx]));
        idx++;
      end
      if (b_pav === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        checks++;
        if ({b_ovf, b_pd} !== e) begin
          errors++;
          $display("FAIL bp_result %0d got %h expected %h", recv, {b_ovf, b_pd}, e);
        end
        $display("backpressure %0d: result %h", recv, {b_ovf, b_pd});
        recv++;
      end
      @(posedge clk); #1;
    end
    b_av1 = 0; b_av2 = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (b_pav === 1'b1) dup++;
      @(posedge clk); #1;
    end
    checks++;
    if (recv != 5 || idx != 5 || dup != 0) begin
      errors++;
      $display("FAIL bp_drain got recv=%0d accepted=%0d extra=%0d expected 5 5 0", recv, idx, dup);
    end
  endtask

  task automatic test_reset_inflight();
    int cyc;
    a_pget = 0;
    a_av1 = 1; a_av2 = 1; a_sub = 0; a_d1 = 8'h18; a_d2 = 8'h24;
    @(posedge clk); #1;
    a_d1 = 8'h11; a_d2 = 8'h22;
    @(posedge clk); #1;
    a_av1 = 0; a_av2 = 0;
    @(posedge clk); #1;
    checks++;
    if (a_pav !== 1'b1) begin
      errors++;
      $display("FAIL inflight_setup got avail=%b expected 1", a_pav);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (a_pav !== 1'b0 || a_pd !== 8'h00 || a_ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got avail=%b data=%h ovf=%b expected 0 00 0", a_pav, a_pd, a_ovf);
    end
    @(posedge clk); #1;
    rst_n = 1;
    a_pget = 1; a_av1 = 1; a_av2 = 1; a_d1 = 8'h05; a_d2 = 8'h03; a_sub = 0;
    #1;
    checks++;
    if (a_g1 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_accept got %b expected 1", a_g1);
    end
    @(posedge clk); #1;
    a_av1 = 0; a_av2 = 0;
    cyc = 1;
    while (a_pav !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 2 || a_pd !== 8'h08 || a_ovf !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_result got latency=%0d %h ovf=%b expected 2 08 0", cyc, a_pd, a_ovf);
    end
    $display("post-reset: 05 + 03 -> %h after %0d cycles", a_pd, cyc);
  endtask

  initial begin
    a_av1 = 0; a_av2 = 0; a_sub = 0; a_pget = 0; a_d1 = '0; a_d2 = '0;
    b_av1 = 0; b_av2 = 0; b_sub = 0; b_pget = 1; b_d1 = '0; b_d2 = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_join_backpressure();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
